// File: rtl/debug_step_pkg.sv
// Shared state encoding for the debug step controller.
package debug_step_pkg;

  typedef enum logic [1:0] {
    ST_HALT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP_CYCLE = 2'd2,
    ST_STEP_INSTR = 2'd3
  } state_t;

  localparam int SYNC_BITS = 4;

endpackage

// File: rtl/step_debouncer.sv
// Debounces the synchronised step button and emits a one-cycle pulse on each accepted rising level.
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_oszClk,
  input  logic i_nReset,
  input  logic i_level,
  output logic o_step
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_step;

  // Level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample; any agreement restarts.
  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (i_level != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= i_level;
          r_cnt   <= '0;
          r_step  <= i_level;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/debug_step_ctrl.sv
// Run/halt/single-step controller with PC breakpoints gating the CPU clock enable.
// Optional cycle counter output enabled by defining DEBUG_CYCLE_COUNTER_EN.
module debug_step_ctrl
  import debug_step_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_BREAKPOINTS = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                                  i_oszClk,
  input  logic                                  i_nReset,
  input  logic                                  i_btnStep,
  input  logic                                  i_swStepNRun,
  input  logic                                  i_swInstrNCycle,
  input  logic                                  i_swEnableBreakpoint,
  input  logic [NUM_BREAKPOINTS*ADDR_WIDTH-1:0] i_breakpointAddress,
  input  logic [NUM_BREAKPOINTS-1:0]            i_breakpointValid,
  input  logic [ADDR_WIDTH-1:0]                 i_pc,
  input  logic                                  i_instrStart,
  output logic                                  o_cpuClkEn,
  output logic                                  o_halted,
  output logic [NUM_BREAKPOINTS-1:0]            o_breakHit,
  output logic [1:0]                            o_state
`ifdef DEBUG_CYCLE_COUNTER_EN
  ,
  output logic [31:0]                           o_cycleCount
`endif
);

  logic [SYNC_BITS-1:0]       r_sync1;
  logic [SYNC_BITS-1:0]       r_sync2;
  state_t                     r_state;
  logic                       r_first_run;
  logic                       r_instr_first;
  logic [NUM_BREAKPOINTS-1:0] r_break_hit;
  logic [NUM_BREAKPOINTS-1:0] w_bp_vec;
  logic                       w_step;
  logic                       w_break_match;
  logic                       w_instr_stop;
  logic                       w_btn_s;
  logic                       w_step_mode;
  logic                       w_instr_mode;
  logic                       w_bp_en;

  // Two-flop synchronisers for the button and all switches.
  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_btnStep, i_swStepNRun, i_swInstrNCycle, i_swEnableBreakpoint};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_btn_s, w_step_mode, w_instr_mode, w_bp_en} = r_sync2;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_oszClk(i_oszClk),
    .i_nReset(i_nReset),
    .i_level (w_btn_s),
    .o_step  (w_step)
  );

  // Per-entry address comparators.
  always_comb begin
    w_bp_vec = '0;
    for (int k = 0; k < NUM_BREAKPOINTS; k++) begin
      w_bp_vec[k] = i_breakpointValid[k] &&
                    (i_breakpointAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == i_pc);
    end
  end

  assign w_break_match = (r_state == ST_RUN) && !r_first_run && w_bp_en &&
                         i_instrStart && (|w_bp_vec);
  assign w_instr_stop  = (r_state == ST_STEP_INSTR) && !r_instr_first && i_instrStart;

  // Clock enable must drop in the same cycle a stop condition is seen, so it is decoded, not registered.
  assign o_cpuClkEn = (r_state != ST_HALT) && !w_break_match && !w_instr_stop;
  assign o_halted   = (r_state == ST_HALT);
  assign o_breakHit = r_break_hit;
  assign o_state    = r_state;

  // Main control FSM.
  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state       <= ST_HALT;
      r_first_run   <= 1'b1;
      r_instr_first <= 1'b0;
      r_break_hit   <= '0;
    end else begin
      case (r_state)
        ST_HALT: begin
          r_first_run <= 1'b1;
          if (w_step) begin
            r_break_hit <= '0;
            if (w_step_mode) begin
              r_instr_first <= 1'b1;
              r_state       <= w_instr_mode ? ST_STEP_INSTR : ST_STEP_CYCLE;
            end else begin
              r_state <= ST_RUN;
            end
          end else if (!w_step_mode && (r_break_hit == '0)) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_HALT;
          end
        end
        ST_RUN: begin
          r_first_run <= 1'b0;
          if (w_break_match) begin
            r_state     <= ST_HALT;
            r_break_hit <= w_bp_vec;
          end else if (w_step_mode) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_STEP_CYCLE: r_state <= ST_HALT;
        ST_STEP_INSTR: begin
          r_instr_first <= 1'b0;
          if (w_instr_stop) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_STEP_INSTR;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

`ifdef DEBUG_CYCLE_COUNTER_EN
  logic [31:0] r_cycle_count;

  // Counts enabled CPU cycles, wrapping naturally at 32 bits.
  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_cycle_count <= 32'd0;
    end else if (o_cpuClkEn) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end else begin
      r_cycle_count <= r_cycle_count;
    end
  end

  assign o_cycleCount = r_cycle_count;
`endif

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed self-checking bench for debug_step_ctrl (ADDR_WIDTH=16, NUM_BREAKPOINTS=2, DEBOUNCE_CYCLES=4).
module tb_debug_step_ctrl;

  logic        clk;
  logic        rst_n;
  logic        btn;
  logic        sw_step;
  logic        sw_instr;
  logic        sw_en;
  logic [31:0] bp_addr;
  logic [1:0]  bp_valid;
  logic [15:0] pc;
  logic        instr_start;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  break_hit;
  logic [1:0]  state;
`ifdef DEBUG_CYCLE_COUNTER_EN
  logic [31:0] cycle_count;
`endif

  int checks;
  int failures;

  debug_step_ctrl #(
    .ADDR_WIDTH(16),
    .NUM_BREAKPOINTS(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_oszClk            (clk),
    .i_nReset            (rst_n),
    .i_btnStep           (btn),
    .i_swStepNRun        (sw_step),
    .i_swInstrNCycle     (sw_instr),
    .i_swEnableBreakpoint(sw_en),
    .i_breakpointAddress (bp_addr),
    .i_breakpointValid   (bp_valid),
    .i_pc                (pc),
    .i_instrStart        (instr_start),
    .o_cpuClkEn          (cpu_en),
    .o_halted            (halted),
    .o_breakHit          (break_hit),
    .o_state             (state)
`ifdef DEBUG_CYCLE_COUNTER_EN
    ,
    .o_cycleCount        (cycle_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit found;
    rst_n = 1'b0; btn = 1'b0; sw_step = 1'b0; sw_instr = 1'b0; sw_en = 1'b0;
    bp_addr = 32'h0000_0000; bp_valid = 2'b00; pc = 16'h0000; instr_start = 1'b0;
    #3;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got=%b exp=1", halted); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpuen got=%b exp=0", cpu_en); end
    checks++; if (break_hit !== 2'b00) begin failures++; $display("FAIL reset_breakhit got=%b exp=00", break_hit); end
    tick(); tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_hold_halted got=%b exp=1", halted); end
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!found && state === 2'd1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL reset_to_run got_state=%0d exp=1 within 4", state); end
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL run_cpuen got=%b exp=1", cpu_en); end
  endtask

  task automatic test_breakpoint();
    bit found;
    bp_addr = {16'h0030, 16'h0028}; bp_valid = 2'b01; sw_en = 1'b1; pc = 16'h0010;
    tick(); tick(); tick();
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL bp_run_cpuen got=%b exp=1", cpu_en); end
    // invalid entry 1 must not match
    pc = 16'h0030; instr_start = 1'b1; #1;
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL bp_invalid_entry got=%b exp=1", cpu_en); end
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bp_invalid_state got=%0d exp=1", state); end
    pc = 16'h0028; #1;
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL bp_match_cpuen got=%b exp=0", cpu_en); end
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL bp_halt_state got=%0d exp=0", state); end
    checks++; if (break_hit !== 2'b01) begin failures++; $display("FAIL bp_breakhit got=%b exp=01", break_hit); end
    tick(); tick(); tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bp_stay_halted got=%b exp=1", halted); end
    btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (state === 2'd1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL bp_resume_timeout state=%0d exp=1", state); end
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL bp_first_run_mask got=%b exp=1", cpu_en); end
    checks++; if (break_hit !== 2'b00) begin failures++; $display("FAIL bp_hit_cleared got=%b exp=00", break_hit); end
    pc = 16'h002A; instr_start = 1'b0;
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bp_continue got=%0d exp=1", state); end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bp_release_run got=%0d exp=1", state); end
  endtask

  task automatic test_step_cycle();
    bit found;
    int pulses;
`ifdef DEBUG_CYCLE_COUNTER_EN
    logic [31:0] cnt0;
`endif
    sw_step = 1'b1; sw_instr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (halted === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL step_enter_halt state=%0d exp=0", state); end
    tick(); tick(); tick();
`ifdef DEBUG_CYCLE_COUNTER_EN
    cnt0 = cycle_count;
`endif
    pulses = 0;
    btn = 1'b1;
    for (int i = 0; i < 16; i++) begin tick(); if (cpu_en === 1'b1) pulses++; end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (cpu_en === 1'b1) pulses++; end
    checks++; if (pulses != 1) begin failures++; $display("FAIL step_cycle_pulses got=%0d exp=1", pulses); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL step_cycle_end got=%0d exp=0", state); end
`ifdef DEBUG_CYCLE_COUNTER_EN
    checks++; if (cycle_count - cnt0 !== 32'd1) begin failures++; $display("FAIL cycle_count_delta got=%0d exp=1", cycle_count - cnt0); end
`endif
  endtask

  task automatic test_step_instr();
    int ustep;
    int pulses;
    sw_instr = 1'b1;
    tick(); tick(); tick();
    ustep = 0;
    for (int p = 0; p < 2; p++) begin
      pulses = 0;
      for (int i = 0; i < 26; i++) begin
        btn = (i < 16);
        instr_start = (ustep == 0);
        #1;
        if (cpu_en === 1'b1) begin
          pulses++;
          ustep = (ustep + 1) % 5;
        end
        tick();
      end
      checks++; if (pulses != 5) begin failures++; $display("FAIL step_instr_pulses press=%0d got=%0d exp=5", p, pulses); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL step_instr_end press=%0d got=%0d exp=0", p, state); end
    end
    instr_start = 1'b0;
  endtask

  task automatic test_bounce();
    logic [27:0] pattern;
    int pulses;
    sw_instr = 1'b0;
    tick(); tick(); tick();
    pattern = {12'h000, 10'h3FF, 6'b110011};
    pulses = 0;
    for (int i = 0; i < 28; i++) begin
      btn = pattern[i];
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", pulses); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL bounce_end got=%0d exp=0", state); end
  endtask

  task automatic test_reset_mid_press();
    int steps;
    int first;
    sw_step = 1'b1; sw_instr = 1'b0; btn = 1'b1;
    rst_n = 1'b0;
    #3;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL midpress_reset_halted got=%b exp=1", halted); end
    tick();
    rst_n = 1'b1;
    steps = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (state === 2'd2) begin
        steps++;
        if (first < 0) first = i;
      end
    end
    checks++; if (steps != 1) begin failures++; $display("FAIL midpress_steps got=%0d exp=1", steps); end
    checks++; if (first != 7) begin failures++; $display("FAIL midpress_first_step got=%0d exp=7", first); end
    btn = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_breakpoint();
    test_step_cycle();
    test_step_instr();
    test_bounce();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
